maze_loader: RTL and testbench

MAZE_LOADER -- requirements
Module: maze_loader

---
 rtl/maze_loader_if.sv | 32 +++
 rtl/maze_loader.sv | 137 +++++++++++++
 tb/tb_maze_loader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/maze_loader_if.sv
// Bundle of stream-input, bit-memory and status signals for maze_loader.
// The master modport is the loader's view; slave is the environment's.
interface maze_loader_if #(
  parameter int ADDR_W = 4,
  parameter int ADDR_H = 4
);
  logic              start;
  logic              in_valid;
  logic              in_data;
  logic              in_ready;
  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr_x;
  logic [ADDR_H-1:0] mem_addr_y;
  logic              mem_wdata;
  logic              mem_rdata;
  logic              busy;
  logic              done;
  logic              chk_err;

  modport master (
    input  start, in_valid, in_data, mem_rdata,
    output in_ready, mem_wr, mem_rd, mem_addr_x, mem_addr_y, mem_wdata,
           busy, done, chk_err
  );

  modport slave (
    output start, in_valid, in_data, mem_rdata,
    input  in_ready, mem_wr, mem_rd, mem_addr_x, mem_addr_y, mem_wdata,
           busy, done, chk_err
  );
endinterface

// File: rtl/maze_loader.sv
// Streams a WIDTH x HEIGHT bit grid into an external bit-memory in row-major
// order, reads it back, and flags a parity mismatch between write and readback.
module maze_loader #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int ADDR_W = 4,
  parameter int ADDR_H = 4
) (
  input  logic          clk,
  input  logic          rst,
  maze_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_H-1:0] Y_LAST = ADDR_H'(HEIGHT - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_x;
  logic [ADDR_H-1:0] r_y;
  logic              r_wpar;
  logic              r_rpar;
  logic              r_in_ready;
  logic              r_mem_rd;
  logic              r_busy;
  logic              r_done;
  logic              r_chk_err;

  logic              w_last_x;
  logic              w_last_cell;
  logic              w_accept;
  logic [ADDR_W-1:0] w_next_x;
  logic [ADDR_H-1:0] w_next_y;

  assign w_last_x    = (r_x == X_LAST);
  assign w_last_cell = w_last_x && (r_y == Y_LAST);
  assign w_next_x    = w_last_x ? '0 : r_x + ADDR_W'(1);
  assign w_next_y    = w_last_x ? r_y + ADDR_H'(1) : r_y;

  // NOTE: the write strobe is combinational so the memory captures the beat on
  // the same edge that the loader accepts it and advances the address.
  assign w_accept = (r_state == S_LOAD) && bus.in_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_wpar     <= 1'b0;
      r_rpar     <= 1'b0;
      r_in_ready <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_chk_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state    <= S_LOAD;
            r_x        <= '0;
            r_y        <= '0;
            r_wpar     <= 1'b0;
            r_rpar     <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_chk_err  <= 1'b0;
          end
        end

        S_LOAD: begin
          if (bus.in_valid) begin
            r_wpar <= r_wpar ^ bus.in_data;
            if (w_last_cell) begin
              r_state    <= S_VERIFY;
              r_x        <= '0;
              r_y        <= '0;
              r_in_ready <= 1'b0;
              r_mem_rd   <= 1'b1;
            end else begin
              r_x <= w_next_x;
              r_y <= w_next_y;
            end
          end
        end

        S_VERIFY: begin
          r_rpar <= r_rpar ^ bus.mem_rdata;
          if (w_last_cell) begin
            r_state  <= S_CHECK;
            r_x      <= '0;
            r_y      <= '0;
            r_mem_rd <= 1'b0;
          end else begin
            r_x <= w_next_x;
            r_y <= w_next_y;
          end
        end

        S_CHECK: begin
          r_chk_err <= r_wpar ^ r_rpar;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_DONE;
        end

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_mem_rd   <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.mem_wr     = w_accept;
  assign bus.mem_wdata  = bus.in_data;
  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_addr_x = r_x;
  assign bus.mem_addr_y = r_y;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.chk_err    = r_chk_err;

endmodule

// File: tb/tb_maze_loader.sv
// Directed bench for maze_loader on a 16x16 grid with a behavioural bit-memory.
module tb_maze_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maze_loader_if #(.ADDR_W(4), .ADDR_H(4)) bus ();

  maze_loader #(.WIDTH(16), .HEIGHT(16), .ADDR_W(4), .ADDR_H(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic mem     [16][16];
  logic exp_mem [16][16];
  logic flip = 1'b0;
  int   wr_cnt = 0;

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      mem[bus.mem_addr_y][bus.mem_addr_x] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr_y][bus.mem_addr_x] ^ flip;

  int tests    = 0;
  int failed   = 0;
  int sidx     = 0;
  int addr_err = 0;
  int gap_err  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    #1;
  endtask

  // Feeds n beats; each beat's address is checked against the stream index.
  task automatic feed(input int n, input bit alt, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = rnd ? 1'($urandom() & 1) : 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      #1;
      if (bus.mem_wr !== 1'b1 || {bus.mem_addr_y, bus.mem_addr_x} !== 8'(sidx))
        addr_err++;
      exp_mem[sidx / 16][sidx % 16] = b;
      sidx++;
      tick();
      if (alt && sidx < 256) begin
        logic [7:0] a;
        bus.in_valid = 1'b0;
        #1;
        a = {bus.mem_addr_y, bus.mem_addr_x};
        if (bus.mem_wr !== 1'b0) gap_err++;
        tick();
        if ({bus.mem_addr_y, bus.mem_addr_x} !== a) gap_err++;
      end
    end
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic run_to_done(output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < 2000) begin
      tick();
      edges++;
    end
  endtask

  function automatic int pattern_mismatches();
    int m = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if (mem[y][x] !== exp_mem[y][x]) m++;
    return m;
  endfunction

  function automatic logic [7:0] outs_vec();
    return {bus.in_ready, bus.mem_wr, bus.mem_rd, bus.busy, bus.done, bus.chk_err,
            |bus.mem_addr_x, |bus.mem_addr_y};
  endfunction

  initial begin
    int e;
    int w0;
    logic [7:0] a;

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    tick();
    tick();
    check("reset_outputs", outs_vec(), 8'h00);
    rst = 1'b1;
    tick();
    check("idle_after_reset", {bus.busy, bus.done, bus.in_ready}, 3'b000);

    // Full load with in_valid held high; start and in_valid arrive together.
    w0 = wr_cnt;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 1'b1;
    #1;
    check("t1_no_ready_in_idle", bus.in_ready, 1'b0);
    check("t1_no_wr_on_start", bus.mem_wr, 1'b0);
    tick();
    bus.start = 1'b0;
    #1;
    check("t1_first_wr_next_cycle", {bus.mem_wr, bus.mem_addr_y, bus.mem_addr_x}, 9'h100);
    sidx = 0; addr_err = 0;
    feed(256, 1'b0, 1'b0);
    check("t1_wr_count_start_edge", wr_cnt - w0, 256);
    run_to_done(e);
    check("t1_latency_edges", 256 + e, 513);
    check("t1_done", bus.done, 1'b1);
    check("t1_chk_err", bus.chk_err, 1'b0);
    check("t1_addr_order", addr_err, 0);
    check("t1_pattern", pattern_mismatches(), 0);

    // Alternate-cycle beats with random data.
    pulse_start();
    w0 = wr_cnt; sidx = 0; addr_err = 0; gap_err = 0;
    feed(256, 1'b1, 1'b1);
    run_to_done(e);
    check("t2_wr_pulses", wr_cnt - w0, 256);
    check("t2_gap_hold", gap_err, 0);
    check("t2_addr_order", addr_err, 0);
    check("t2_pattern", pattern_mismatches(), 0);
    check("t2_done_ok", {bus.done, bus.chk_err}, 2'b10);

    // Corrupt one readback bit during VERIFY.
    pulse_start();
    sidx = 0; addr_err = 0;
    feed(256, 1'b0, 1'b1);
    check("t3_verify_flags", {bus.mem_rd, bus.in_ready, bus.busy, bus.mem_wr}, 4'b1010);
    for (int i = 0; i < 20; i++) tick();
    flip = 1'b1;
    tick();
    flip = 1'b0;
    run_to_done(e);
    check("t3_done", bus.done, 1'b1);
    check("t3_chk_err", bus.chk_err, 1'b1);

    // Start from DONE restarts; start during LOAD is ignored.
    pulse_start();
    check("t5_restart_flags", {bus.done, bus.chk_err, bus.busy, bus.in_ready}, 4'b0011);
    check("t5_restart_addr", {bus.mem_addr_y, bus.mem_addr_x}, 8'h00);
    sidx = 0; addr_err = 0;
    feed(50, 1'b0, 1'b1);
    a = {bus.mem_addr_y, bus.mem_addr_x};
    pulse_start();
    check("t5_start_in_load_addr", {bus.mem_addr_y, bus.mem_addr_x}, a);
    check("t5_start_in_load_state", {bus.in_ready, bus.busy}, 2'b11);
    feed(206, 1'b0, 1'b1);
    run_to_done(e);
    check("t5_addr_order", addr_err, 0);
    check("t5_done_ok", {bus.done, bus.chk_err}, 2'b10);

    // Reset in the middle of a load.
    pulse_start();
    sidx = 0; addr_err = 0;
    feed(100, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("t4_async_reset_outputs", outs_vec(), 8'h00);
    tick();
    rst = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) tick();
    check("t4_stay_idle", {bus.busy, bus.in_ready, bus.done}, 3'b000);
    check("t4_no_resume_writes", wr_cnt - w0, 0);
    bus.in_valid = 1'b0;
    pulse_start();
    sidx = 0; addr_err = 0;
    feed(256, 1'b0, 1'b1);
    run_to_done(e);
    check("t4_reload_addr_order", addr_err, 0);
    check("t4_reload_pattern", pattern_mismatches(), 0);
    check("t4_done_ok", {bus.done, bus.chk_err}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
